// File: rtl/wt_mem_arbiter.sv
// Round-robin arbiter sharing one memory adapter request port between I$ and D$,
// with per-source credit counters, return demultiplexing and drain/idle support.
module wt_mem_arbiter #(
  parameter  int unsigned ReqWidth       = 64,
  parameter  int unsigned MaxOutstanding = 4,
  localparam int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                ic_req_i,
  output logic                ic_ack_o,
  input  logic [ReqWidth-1:0] ic_data_i,
  input  logic                dc_req_i,
  output logic                dc_ack_o,
  input  logic [ReqWidth-1:0] dc_data_i,
  input  logic                drain_i,
  output logic                mem_req_o,
  input  logic                mem_ack_i,
  output logic [ReqWidth-1:0] mem_data_o,
  output logic                mem_src_o,
  input  logic                rtrn_vld_i,
  input  logic                rtrn_src_i,
  output logic                ic_rtrn_vld_o,
  output logic                dc_rtrn_vld_o,
  output logic [CntWidth-1:0] ic_cnt_o,
  output logic [CntWidth-1:0] dc_cnt_o,
  output logic                idle_o,
  output logic                underflow_o
);

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e                state_q, state_d;
  logic                  last_src_q;
  logic [ReqWidth-1:0]   mem_data_q;
  logic                  mem_src_q;
  logic [CntWidth-1:0]   ic_cnt_q, dc_cnt_q;
  logic                  underflow_q;
  logic                  ic_elig, dc_elig;
  logic                  ic_grant, dc_grant;
  logic                  ic_dec, dc_dec;
  logic                  ic_uflow, dc_uflow;

  assign ic_elig = ic_req_i & (ic_cnt_q < MaxCnt) & ~drain_i & (state_q == IDLE);
  assign dc_elig = dc_req_i & (dc_cnt_q < MaxCnt) & ~drain_i & (state_q == IDLE);

  // On a tie the source that did not win last time gets the port.
  always_comb begin
    state_d  = state_q;
    ic_grant = 1'b0;
    dc_grant = 1'b0;
    case (state_q)
      IDLE: begin
        ic_grant = ic_elig & (~dc_elig | last_src_q);
        dc_grant = dc_elig & (~ic_elig | ~last_src_q);
        if (ic_elig | dc_elig) state_d = BUSY;
      end
      BUSY: begin
        if (mem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_data_q <= '0;
      mem_src_q  <= 1'b0;
      last_src_q <= 1'b1;
    end else if (ic_grant | dc_grant) begin
      mem_data_q <= dc_grant ? dc_data_i : ic_data_i;
      mem_src_q  <= dc_grant;
      last_src_q <= dc_grant;
    end
  end

  assign ic_dec   = rtrn_vld_i & ~rtrn_src_i;
  assign dc_dec   = rtrn_vld_i &  rtrn_src_i;
  assign ic_uflow = ic_dec & ~ic_grant & (ic_cnt_q == '0);
  assign dc_uflow = dc_dec & ~dc_grant & (dc_cnt_q == '0);

  // A grant and a return in the same cycle cancel; a return at zero saturates.
  function automatic logic [CntWidth-1:0] next_cnt(input logic [CntWidth-1:0] cnt,
                                                   input logic inc, input logic dec);
    logic [CntWidth-1:0] res;
    res = cnt;
    if (inc && !dec)                 res = cnt + CntWidth'(1);
    else if (dec && !inc && cnt != '0) res = cnt - CntWidth'(1);
    return res;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ic_cnt_q    <= '0;
      dc_cnt_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      ic_cnt_q    <= next_cnt(ic_cnt_q, ic_grant, ic_dec);
      dc_cnt_q    <= next_cnt(dc_cnt_q, dc_grant, dc_dec);
      underflow_q <= ic_uflow | dc_uflow;
    end
  end

  assign ic_ack_o      = ic_grant;
  assign dc_ack_o      = dc_grant;
  assign mem_req_o     = (state_q == BUSY);
  assign mem_data_o    = mem_data_q;
  assign mem_src_o     = mem_src_q;
  assign ic_rtrn_vld_o = ic_dec;
  assign dc_rtrn_vld_o = dc_dec;
  assign ic_cnt_o      = ic_cnt_q;
  assign dc_cnt_o      = dc_cnt_q;
  assign idle_o        = (state_q == IDLE) & (ic_cnt_q == '0) & (dc_cnt_q == '0);
  assign underflow_o   = underflow_q;

  // Requesters must hold their request until it is acknowledged.
  ic_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                (ic_req_i && !ic_ack_o) |=> ic_req_i);
  dc_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                (dc_req_i && !dc_ack_o) |=> dc_req_i);

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// Scenario bench for wt_mem_arbiter; downstream handshakes are checked against
// a queue of expected (source, payload) entries.
module tb_wt_mem_arbiter;

  localparam int RW = 64;
  localparam int CW = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          ic_req_i, dc_req_i, drain_i, mem_ack_i, rtrn_vld_i, rtrn_src_i;
  logic [RW-1:0] ic_data_i, dc_data_i;
  logic          ic_ack_o, dc_ack_o, mem_req_o, mem_src_o;
  logic          ic_rtrn_vld_o, dc_rtrn_vld_o, idle_o, underflow_o;
  logic [RW-1:0] mem_data_o;
  logic [CW-1:0] ic_cnt_o, dc_cnt_o;

  typedef struct packed {
    logic          src;
    logic [RW-1:0] data;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int n_compared   = 0;
  int n_mismatched = 0;

  wt_mem_arbiter #(.ReqWidth(RW), .MaxOutstanding(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ic_req_i(ic_req_i), .ic_ack_o(ic_ack_o), .ic_data_i(ic_data_i),
    .dc_req_i(dc_req_i), .dc_ack_o(dc_ack_o), .dc_data_i(dc_data_i),
    .drain_i(drain_i),
    .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i), .mem_data_o(mem_data_o), .mem_src_o(mem_src_o),
    .rtrn_vld_i(rtrn_vld_i), .rtrn_src_i(rtrn_src_i),
    .ic_rtrn_vld_o(ic_rtrn_vld_o), .dc_rtrn_vld_o(dc_rtrn_vld_o),
    .ic_cnt_o(ic_cnt_o), .dc_cnt_o(dc_cnt_o),
    .idle_o(idle_o), .underflow_o(underflow_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Downstream handshake monitor, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (rst_ni && mem_req_o && mem_ack_i) begin
      sb_entry_t exp_e;
      n_compared++;
      if (sb_q.size() == 0) begin
        n_mismatched++;
        $display("[TB] FAIL sb_unexpected got src=%0b data=%h want no request", mem_src_o, mem_data_o);
      end else begin
        exp_e = sb_q.pop_front();
        if (mem_src_o !== exp_e.src || mem_data_o !== exp_e.data) begin
          n_mismatched++;
          $display("[TB] FAIL sb_payload got src=%0b data=%h want src=%0b data=%h",
                   mem_src_o, mem_data_o, exp_e.src, exp_e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    ic_req_i = 0; dc_req_i = 0; drain_i = 0; mem_ack_i = 0;
    rtrn_vld_i = 0; rtrn_src_i = 0; ic_data_i = '0; dc_data_i = '0;
  endtask

  task automatic apply_reset();
    rst_ni = 0;
    idle_inputs();
    sb_q.delete();
    tick(); tick();
    rst_ni = 1;
    tick();
  endtask

  task automatic check_sb_empty(input string name);
    n_compared++;
    if (sb_q.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL %s_sb_empty got %0d pending want 0", name, sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst_ni = 0;
    idle_inputs();
    #2;
    n_compared++; if (mem_req_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_mem_req got %0b want 0", mem_req_o); end
    n_compared++; if (mem_data_o !== '0) begin n_mismatched++; $display("[TB] FAIL rst_mem_data got %h want 0", mem_data_o); end
    n_compared++; if (mem_src_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_mem_src got %0b want 0", mem_src_o); end
    n_compared++; if ({ic_ack_o, dc_ack_o} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL rst_acks got %b want 00", {ic_ack_o, dc_ack_o}); end
    n_compared++; if (ic_cnt_o !== '0 || dc_cnt_o !== '0) begin n_mismatched++; $display("[TB] FAIL rst_cnts got %0d/%0d want 0/0", ic_cnt_o, dc_cnt_o); end
    n_compared++; if (idle_o !== 1'b1 || underflow_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_idle_uflow got %0b/%0b want 1/0", idle_o, underflow_o); end
    tick(); tick();
    rst_ni = 1;
    tick();
  endtask

  task automatic test_single_ic();
    ic_req_i = 1; ic_data_i = 64'hA5A5_0000_1234_5678;
    settle();
    n_compared++; if (ic_ack_o !== 1'b1 || dc_ack_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_ack got %0b/%0b want 1/0", ic_ack_o, dc_ack_o); end
    sb_q.push_back('{src: 1'b0, data: ic_data_i});
    for (int c = 1; c <= 4; c++) begin
      tick();
      ic_req_i = 0;
      mem_ack_i = (c == 4);
      settle();
      n_compared++; if (mem_req_o !== 1'b1 || mem_src_o !== 1'b0 || mem_data_o !== 64'hA5A5_0000_1234_5678) begin n_mismatched++; $display("[TB] FAIL single_busy_c%0d got req=%0b src=%0b data=%h want 1/0/a5a5000012345678", c, mem_req_o, mem_src_o, mem_data_o); end
      n_compared++; if (ic_ack_o !== 1'b0 || ic_cnt_o !== 3'd1) begin n_mismatched++; $display("[TB] FAIL single_cnt_c%0d got ack=%0b cnt=%0d want 0/1", c, ic_ack_o, ic_cnt_o); end
    end
    tick();
    mem_ack_i = 0;
    settle();
    n_compared++; if (mem_req_o !== 1'b0 || idle_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_c5 got req=%0b idle=%0b want 0/0", mem_req_o, idle_o); end
    rtrn_vld_i = 1; rtrn_src_i = 0;
    settle();
    n_compared++; if (ic_rtrn_vld_o !== 1'b1 || dc_rtrn_vld_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_rtrn got %0b/%0b want 1/0", ic_rtrn_vld_o, dc_rtrn_vld_o); end
    tick();
    rtrn_vld_i = 0;
    settle();
    n_compared++; if (ic_cnt_o !== 3'd0 || idle_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_done got cnt=%0d idle=%0b want 0/1", ic_cnt_o, idle_o); end
    check_sb_empty("single");
  endtask

  task automatic test_round_robin();
    logic exp_ic, exp_dc;
    apply_reset();
    ic_req_i = 1; dc_req_i = 1; mem_ack_i = 1;
    for (int k = 0; k < 8; k++) begin
      ic_data_i = 64'h1000 + 64'(k);
      dc_data_i = 64'h2000 + 64'(k);
      settle();
      exp_ic = (k % 4 == 0);
      exp_dc = (k % 4 == 2);
      n_compared++; if (ic_ack_o !== exp_ic || dc_ack_o !== exp_dc) begin n_mismatched++; $display("[TB] FAIL rr_k%0d got %0b/%0b want %0b/%0b", k, ic_ack_o, dc_ack_o, exp_ic, exp_dc); end
      if (exp_ic) sb_q.push_back('{src: 1'b0, data: ic_data_i});
      if (exp_dc) sb_q.push_back('{src: 1'b1, data: dc_data_i});
      tick();
    end
    n_compared++; if (ic_cnt_o !== 3'd2 || dc_cnt_o !== 3'd2) begin n_mismatched++; $display("[TB] FAIL rr_cnts got %0d/%0d want 2/2", ic_cnt_o, dc_cnt_o); end
    check_sb_empty("rr");
    apply_reset();
  endtask

  task automatic test_credit_limit();
    int acks = 0;
    int late_acks = 0;
    dc_req_i = 1; mem_ack_i = 1;
    for (int k = 0; k < 4; k++) sb_q.push_back('{src: 1'b1, data: 64'hDC00_0000_0000_00C4});
    dc_data_i = 64'hDC00_0000_0000_00C4;
    for (int c = 0; c < 16; c++) begin
      settle();
      if (dc_ack_o === 1'b1) begin
        acks++;
        if (c >= 8) late_acks++;
      end
      tick();
    end
    n_compared++; if (acks != 4 || late_acks != 0) begin n_mismatched++; $display("[TB] FAIL credit_acks got %0d (late %0d) want 4 (late 0)", acks, late_acks); end
    n_compared++; if (dc_cnt_o !== 3'd4) begin n_mismatched++; $display("[TB] FAIL credit_cnt got %0d want 4", dc_cnt_o); end
    rtrn_vld_i = 1; rtrn_src_i = 1;
    settle();
    n_compared++; if (dc_rtrn_vld_o !== 1'b1 || ic_rtrn_vld_o !== 1'b0 || dc_ack_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL credit_rtrn got dc=%0b ic=%0b ack=%0b want 1/0/0", dc_rtrn_vld_o, ic_rtrn_vld_o, dc_ack_o); end
    tick();
    rtrn_vld_i = 0; rtrn_src_i = 0;
    dc_data_i = 64'hDC00_0000_0000_0005;
    settle();
    n_compared++; if (dc_cnt_o !== 3'd3 || dc_ack_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL credit_regrant got cnt=%0d ack=%0b want 3/1", dc_cnt_o, dc_ack_o); end
    sb_q.push_back('{src: 1'b1, data: dc_data_i});
    tick();
    tick();
    n_compared++; if (dc_cnt_o !== 3'd4 || dc_ack_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL credit_full_again got cnt=%0d ack=%0b want 4/0", dc_cnt_o, dc_ack_o); end
    check_sb_empty("credit");
    apply_reset();
  endtask

  task automatic test_same_cycle();
    ic_req_i = 1; mem_ack_i = 1;
    for (int c = 0; c < 5; c++) begin
      ic_data_i = 64'h3000 + 64'(c);
      rtrn_vld_i = (c == 4); rtrn_src_i = 0;
      settle();
      if (c % 2 == 0) sb_q.push_back('{src: 1'b0, data: ic_data_i});
      if (c == 4) begin
        n_compared++; if (ic_cnt_o !== 3'd2 || ic_ack_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL same_pre got cnt=%0d ack=%0b want 2/1", ic_cnt_o, ic_ack_o); end
        n_compared++; if (ic_rtrn_vld_o !== 1'b1 || dc_rtrn_vld_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL same_route got %0b/%0b want 1/0", ic_rtrn_vld_o, dc_rtrn_vld_o); end
      end
      tick();
    end
    ic_req_i = 0; rtrn_vld_i = 0;
    settle();
    n_compared++; if (ic_cnt_o !== 3'd2 || mem_req_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL same_post got cnt=%0d req=%0b want 2/1", ic_cnt_o, mem_req_o); end
    tick();
    check_sb_empty("same");
    apply_reset();
  endtask

  task automatic test_drain();
    dc_req_i = 1; dc_data_i = 64'hD4A1_0000_0000_0001;
    settle();
    n_compared++; if (dc_ack_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL drain_grant got %0b want 1", dc_ack_o); end
    sb_q.push_back('{src: 1'b1, data: dc_data_i});
    tick();
    dc_req_i = 0; drain_i = 1; ic_req_i = 1; ic_data_i = 64'h1C1C;
    for (int c = 1; c <= 6; c++) begin
      mem_ack_i = (c == 3);
      settle();
      if (c <= 3) begin
        n_compared++; if (mem_req_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL drain_hold_c%0d got %0b want 1", c, mem_req_o); end
      end else begin
        n_compared++; if (mem_req_o !== 1'b0 || idle_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL drain_idle_c%0d got req=%0b idle=%0b want 0/0", c, mem_req_o, idle_o); end
      end
      n_compared++; if (ic_ack_o !== 1'b0 || dc_ack_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL drain_noack_c%0d got %0b/%0b want 0/0", c, ic_ack_o, dc_ack_o); end
      tick();
    end
    mem_ack_i = 0; rtrn_vld_i = 1; rtrn_src_i = 1;
    settle();
    n_compared++; if (dc_rtrn_vld_o !== 1'b1 || ic_rtrn_vld_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL drain_rtrn got %0b/%0b want 1/0", dc_rtrn_vld_o, ic_rtrn_vld_o); end
    tick();
    rtrn_vld_i = 0; rtrn_src_i = 0;
    settle();
    n_compared++; if (idle_o !== 1'b1 || dc_cnt_o !== 3'd0 || ic_ack_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL drain_quiet got idle=%0b cnt=%0d ack=%0b want 1/0/0", idle_o, dc_cnt_o, ic_ack_o); end
    tick();
    drain_i = 0;
    settle();
    n_compared++; if (ic_ack_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL drain_release got %0b want 1", ic_ack_o); end
    sb_q.push_back('{src: 1'b0, data: ic_data_i});
    tick();
    ic_req_i = 0; mem_ack_i = 1;
    tick();
    mem_ack_i = 0;
    check_sb_empty("drain");
    apply_reset();
  endtask

  task automatic test_underflow();
    rtrn_vld_i = 1; rtrn_src_i = 0;
    settle();
    n_compared++; if (ic_rtrn_vld_o !== 1'b1 || underflow_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL uflow_pre got rtrn=%0b uflow=%0b want 1/0", ic_rtrn_vld_o, underflow_o); end
    tick();
    rtrn_vld_i = 0;
    settle();
    n_compared++; if (underflow_o !== 1'b1 || ic_cnt_o !== 3'd0) begin n_mismatched++; $display("[TB] FAIL uflow_pulse got uflow=%0b cnt=%0d want 1/0", underflow_o, ic_cnt_o); end
    tick();
    n_compared++; if (underflow_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL uflow_clear got %0b want 0", underflow_o); end
  endtask

  task automatic test_reset_mid_busy();
    ic_req_i = 1; ic_data_i = 64'hBEEF;
    settle();
    tick();
    ic_req_i = 0;
    settle();
    n_compared++; if (mem_req_o !== 1'b1 || ic_cnt_o !== 3'd1) begin n_mismatched++; $display("[TB] FAIL rstbusy_pre got req=%0b cnt=%0d want 1/1", mem_req_o, ic_cnt_o); end
    #2;
    rst_ni = 0;
    #1;
    n_compared++; if (mem_req_o !== 1'b0 || ic_cnt_o !== 3'd0 || idle_o !== 1'b1 || mem_data_o !== '0) begin n_mismatched++; $display("[TB] FAIL rstbusy_clear got req=%0b cnt=%0d idle=%0b data=%h want 0/0/1/0", mem_req_o, ic_cnt_o, idle_o, mem_data_o); end
    tick();
    rst_ni = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_ic();
    test_round_robin();
    test_credit_limit();
    test_same_cycle();
    test_drain();
    test_underflow();
    test_reset_mid_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/wt_mem_arbiter.md
Name: wt_mem_arbiter

Overview:
- Shares the single memory adapter request port between the I$ miss path and the D$ miss/write path.
- Round-robin arbitration with a registered downstream request stage.
- Per-requester outstanding-transaction counters with a credit limit; demultiplexes return-valid strobes by source.
- Drain input stops new grants; idle output reports when the memory side is quiescent (flush/fence support).

Parameters:
ReqWidth, 64, width of the request payload (both requesters and downstream)
MaxOutstanding, 4, max in-flight transactions per requester (>=1)
CntWidth, $clog2(MaxOutstanding+1), counter width (derived, not overridable)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
ic_req_i  in  1  I$ request valid, held until ic_ack_o
ic_ack_o  out  1  one-cycle grant/accept pulse to I$
ic_data_i  in  ReqWidth  I$ request payload
dc_req_i  in  1  D$ request valid, held until dc_ack_o
dc_ack_o  out  1  one-cycle grant/accept pulse to D$
dc_data_i  in  ReqWidth  D$ request payload
drain_i  in  1  block new grants while high
mem_req_o  out  1  downstream request valid (registered)
mem_ack_i  in  1  downstream accept
mem_data_o  out  ReqWidth  latched payload
mem_src_o  out  1  0=I$, 1=D$ for the latched request
rtrn_vld_i  in  1  return beat valid from adapter
rtrn_src_i  in  1  source of return (0=I$, 1=D$)
ic_rtrn_vld_o  out  1  return valid routed to I$ (combinational)
dc_rtrn_vld_o  out  1  return valid routed to D$ (combinational)
ic_cnt_o  out  CntWidth  I$ outstanding count
dc_cnt_o  out  CntWidth  D$ outstanding count
idle_o  out  1  no held request and both counters zero
underflow_o  out  1  one-cycle pulse: return for a source whose count is 0

Behaviour:
- Reset values: mem_req_o=0, mem_data_o=0, mem_src_o=0, ic_ack_o=dc_ack_o=0, counters=0, underflow_o=0, idle_o=1. Round-robin pointer last_src=1, so I$ wins the first tie.
- FSM states:
  - IDLE: no payload held.
  - BUSY: payload held, mem_req_o=1.
- Eligibility: requester X is eligible when X_req_i=1, its count < MaxOutstanding, drain_i=0, and state=IDLE.
- IDLE transitions:
  - If any requester is eligible, grant one: ack pulses combinationally this cycle; payload and src are latched; last_src updates; state goes to BUSY next cycle, so mem_req_o rises 1 cycle after grant.
  - Tie: grant the source != last_src.
- BUSY: hold mem_req_o/mem_data_o/mem_src_o stable until mem_ack_i=1, then go to IDLE next cycle. No grant is issued in the ack cycle, giving at most one grant per 2 cycles. The pipeline bubble is accepted.
- Counters:
  - Increment on the upstream ack (grant).
  - Decrement when rtrn_vld_i for that source.
  - Same-cycle increment and decrement leave the count unchanged.
  - Decrement at 0: count stays 0 and underflow_o pulses next cycle.
  - Increment cannot exceed MaxOutstanding because eligibility is gated.
- Return routing: ic_rtrn_vld_o = rtrn_vld_i & ~rtrn_src_i; dc_rtrn_vld_o = rtrn_vld_i & rtrn_src_i. Zero latency; routing is independent of state and drain.
- drain_i:
  - Blocks only new grants.
  - A held BUSY request still completes.
  - Counters still decrement on returns.
- idle_o = (state==IDLE) & (ic_cnt==0) & (dc_cnt==0), registered-state based; may be 1 while drain_i=0.
- A requester dropping req_i before its ack is a protocol violation; the arbiter does not guard against it (simulation assertion required).
- Reset mid-operation: all state clears immediately. A held request is lost; the adapter is reset in the same domain.

Test Plan:
- Single I$ request, mem_ack_i after 3 cycles -> ic_ack_o at cycle 0; mem_req_o cycles 1-4 with mem_src_o=0 and data=ic_data_i; ic_cnt_o=1; IDLE at cycle 5.
- Both req_i held high, mem_ack_i tied 1 -> grants alternate I$,D$,I$,D$ starting with I$; one grant every 2 cycles.
- MaxOutstanding=4, D$ requests continuously with no returns -> exactly 4 dc_ack_o pulses, dc_cnt_o=4, then no grant. One rtrn_vld_i with src=1 -> dc_cnt_o=3 and the next D$ grant follows.
- Grant to I$ in the same cycle as rtrn_vld_i src=0 with ic_cnt=2 -> ic_cnt_o stays 2; ic_rtrn_vld_o=1, dc_rtrn_vld_o=0.
- drain_i=1 while BUSY with one D$ outstanding -> held request completes, no new acks; after the return idle_o=1 and dc_cnt_o=0.
- rtrn_vld_i src=0 with ic_cnt=0 -> ic_cnt_o stays 0, underflow_o=1 for exactly one cycle; async reset asserted mid-BUSY -> mem_req_o=0, counters=0, idle_o=1 immediately.
